// File: rtl/cpu_pkg.sv
// Shared widths, the no-writeback tag and lane slicing helpers for the
// VLIW issue-stage register.
package cpu_pkg;

   localparam int DATA_W    = 16;
   localparam int TAG_W     = 5;
   localparam int CTRL_W    = 6;
   localparam int NO_WB_TAG = 0;

   function automatic int lane_base(input int lane, input int width);
      return lane * width;
   endfunction

   function automatic int src_base(input int lane, input int src,
                                   input int nsrc, input int width);
      return (lane * nsrc + src) * width;
   endfunction

endpackage

// File: rtl/vliw_lane_reg.sv
// One issue slot of the VLIW stage register: squash on predicate-false or
// empty slot, suppress writeback tag when the op does not write Rd.
module vliw_lane_reg
   import cpu_pkg::*;
#(
   parameter int NUM_SRC = 3,
   parameter int DATA_W  = cpu_pkg::DATA_W,
   parameter int TAG_W   = cpu_pkg::TAG_W,
   parameter int CTRL_W  = cpu_pkg::CTRL_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      stall,
   input  logic                      flush,
   input  logic                      valid,
   input  logic                      cnd,
   input  logic                      wr_en,
   input  logic [CTRL_W-1:0]         ctrl,
   input  logic [NUM_SRC*DATA_W-1:0] src,
   input  logic [TAG_W-1:0]          rd_tag,
   input  logic [TAG_W-1:0]          imm,
   output logic                      out_valid,
   output logic [CTRL_W-1:0]         out_ctrl,
   output logic [NUM_SRC*DATA_W-1:0] out_src,
   output logic [TAG_W-1:0]          out_rd_tag,
   output logic [TAG_W-1:0]          out_imm
);

   localparam logic [TAG_W-1:0] NO_WB = TAG_W'(NO_WB_TAG);

   logic keep;

   assign keep = valid & ~cnd;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_ctrl   <= '0;
         out_src    <= '0;
         out_rd_tag <= NO_WB;
         out_imm    <= '0;
      end else if (!stall) begin
         if (flush) begin
            out_valid  <= 1'b0;
            out_ctrl   <= '0;
            out_rd_tag <= NO_WB;
         end else begin
            out_src    <= src;
            out_imm    <= imm;
            out_valid  <= keep;
            out_ctrl   <= keep ? ctrl : '0;
            out_rd_tag <= (keep && wr_en) ? rd_tag : NO_WB;
         end
      end
   end

endmodule

// File: rtl/vliw_stage_reg.sv
// Multi-lane VLIW pipeline register with registered mispredict flush.
// Define VLIW_STAGE_REG_PERF_EN to add the saturating squash_cnt output.
module vliw_stage_reg
   import cpu_pkg::*;
#(
   parameter int NUM_LANES = 4,
   parameter int NUM_SRC   = 3,
   parameter int DATA_W    = cpu_pkg::DATA_W,
   parameter int TAG_W     = cpu_pkg::TAG_W,
   parameter int CTRL_W    = cpu_pkg::CTRL_W
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                stall,
   input  logic                                mispred,
   input  logic [NUM_LANES-1:0]                in_valid,
   input  logic [NUM_LANES-1:0]                in_cnd,
   input  logic [NUM_LANES-1:0]                in_wr_en,
   input  logic [NUM_LANES*CTRL_W-1:0]         in_ctrl,
   input  logic [NUM_LANES*NUM_SRC*DATA_W-1:0] in_src,
   input  logic [NUM_LANES*TAG_W-1:0]          in_rd_tag,
   input  logic [NUM_LANES*TAG_W-1:0]          in_imm,
   output logic [NUM_LANES-1:0]                out_valid,
   output logic [NUM_LANES*CTRL_W-1:0]         out_ctrl,
   output logic [NUM_LANES*NUM_SRC*DATA_W-1:0] out_src,
   output logic [NUM_LANES*TAG_W-1:0]          out_rd_tag,
   output logic [NUM_LANES*TAG_W-1:0]          out_imm
`ifdef VLIW_STAGE_REG_PERF_EN
   ,
   output logic [15:0]                         squash_cnt
`endif
);

   localparam int SW = NUM_SRC * DATA_W;

   logic flush_pend;

   // A pending flush survives stalls and is only consumed by a moving cycle.
   always_ff @(posedge clk) begin
      if (rst) flush_pend <= 1'b0;
      else     flush_pend <= mispred | (flush_pend & stall);
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      vliw_lane_reg #(
         .NUM_SRC (NUM_SRC),
         .DATA_W  (DATA_W),
         .TAG_W   (TAG_W),
         .CTRL_W  (CTRL_W)
      ) u_lane (
         .clk        (clk),
         .rst        (rst),
         .stall      (stall),
         .flush      (flush_pend),
         .valid      (in_valid[i]),
         .cnd        (in_cnd[i]),
         .wr_en      (in_wr_en[i]),
         .ctrl       (in_ctrl[lane_base(i, CTRL_W) +: CTRL_W]),
         .src        (in_src[src_base(i, 0, NUM_SRC, DATA_W) +: SW]),
         .rd_tag     (in_rd_tag[lane_base(i, TAG_W) +: TAG_W]),
         .imm        (in_imm[lane_base(i, TAG_W) +: TAG_W]),
         .out_valid  (out_valid[i]),
         .out_ctrl   (out_ctrl[lane_base(i, CTRL_W) +: CTRL_W]),
         .out_src    (out_src[src_base(i, 0, NUM_SRC, DATA_W) +: SW]),
         .out_rd_tag (out_rd_tag[lane_base(i, TAG_W) +: TAG_W]),
         .out_imm    (out_imm[lane_base(i, TAG_W) +: TAG_W])
      );
   end

`ifdef VLIW_STAGE_REG_PERF_EN
   localparam int CNT_W = $clog2(NUM_LANES + 1);

   logic [NUM_LANES-1:0] sq;
   logic [CNT_W-1:0]     n_sq;
   logic [16:0]          sum;

   assign sq  = flush_pend ? '1 : (~in_valid | in_cnd);
   assign sum = {1'b0, squash_cnt} + 17'(n_sq);

   always_comb begin
      n_sq = '0;
      for (int i = 0; i < NUM_LANES; i++)
         n_sq = n_sq + CNT_W'(sq[i]);
   end

   always_ff @(posedge clk) begin
      if (rst)         squash_cnt <= '0;
      else if (!stall) squash_cnt <= sum[16] ? 16'hFFFF : sum[15:0];
   end
`endif

endmodule

// File: tb/tb_vliw_stage_reg.sv
// Directed self-checking bench for vliw_stage_reg.
module tb_vliw_stage_reg;

   localparam int L = 4;
   localparam int S = 3;
   localparam int D = 16;
   localparam int T = 5;
   localparam int C = 6;

   logic             clk = 1'b0;
   logic             rst;
   logic             stall;
   logic             mispred;
   logic [L-1:0]     in_valid;
   logic [L-1:0]     in_cnd;
   logic [L-1:0]     in_wr_en;
   logic [L*C-1:0]   in_ctrl;
   logic [L*S*D-1:0] in_src;
   logic [L*T-1:0]   in_rd_tag;
   logic [L*T-1:0]   in_imm;
   logic [L-1:0]     out_valid;
   logic [L*C-1:0]   out_ctrl;
   logic [L*S*D-1:0] out_src;
   logic [L*T-1:0]   out_rd_tag;
   logic [L*T-1:0]   out_imm;
`ifdef VLIW_STAGE_REG_PERF_EN
   logic [15:0]      squash_cnt;
`endif

   int total = 0;
   int bad   = 0;
   logic [L*S*D-1:0] exp_src;

   vliw_stage_reg #(
      .NUM_LANES (L),
      .NUM_SRC   (S),
      .DATA_W    (D),
      .TAG_W     (T),
      .CTRL_W    (C)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .mispred    (mispred),
      .in_valid   (in_valid),
      .in_cnd     (in_cnd),
      .in_wr_en   (in_wr_en),
      .in_ctrl    (in_ctrl),
      .in_src     (in_src),
      .in_rd_tag  (in_rd_tag),
      .in_imm     (in_imm),
      .out_valid  (out_valid),
      .out_ctrl   (out_ctrl),
      .out_src    (out_src),
      .out_rd_tag (out_rd_tag),
      .out_imm    (out_imm)
`ifdef VLIW_STAGE_REG_PERF_EN
      ,
      .squash_cnt (squash_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [191:0] got,
                      input logic [191:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic set_lane(input int i, input logic v, input logic cn,
                           input logic we, input logic [C-1:0] ct,
                           input logic [T-1:0] rd, input logic [T-1:0] im);
      in_valid[i]        = v;
      in_cnd[i]          = cn;
      in_wr_en[i]        = we;
      in_ctrl[i*C +: C]  = ct;
      in_rd_tag[i*T +: T] = rd;
      in_imm[i*T +: T]   = im;
   endtask

   task automatic fill_src(input logic [7:0] base);
      for (int i = 0; i < L; i++)
         for (int j = 0; j < S; j++)
            in_src[((i * S) + j) * D +: D] = {base, 4'(i), 4'(j)};
   endtask

   task automatic std_bundle();
      for (int i = 0; i < L; i++)
         set_lane(i, 1'b1, 1'b0, 1'b1, C'(i + 1), T'(i + 3), T'(i + 10));
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; mispred = 1'b0;
      in_valid = '0; in_cnd = '0; in_wr_en = '0; in_ctrl = '0;
      in_rd_tag = '0; in_imm = '0;
      fill_src(8'h5A);
      std_bundle();
      tick();
      chk("rst_valid", out_valid, 0);
      chk("rst_ctrl",  out_ctrl, 0);
      chk("rst_src",   out_src, 0);
      chk("rst_tag",   out_rd_tag, 0);
      chk("rst_imm",   out_imm, 0);
      rst = 1'b0;

      std_bundle();
      fill_src(8'hA1);
      exp_src = in_src;
      tick();
      chk("all_tag",   out_rd_tag, {5'd6, 5'd5, 5'd4, 5'd3});
      chk("all_valid", out_valid, 4'b1111);
      chk("all_ctrl",  out_ctrl, {6'd4, 6'd3, 6'd2, 6'd1});
      chk("all_src",   out_src, exp_src);
      chk("all_imm",   out_imm, {5'd13, 5'd12, 5'd11, 5'd10});

      set_lane(2, 1'b1, 1'b1, 1'b1, 6'd7, 5'd9, 5'd1);
      tick();
      chk("cnd_valid", out_valid, 4'b1011);
      chk("cnd_tag",   out_rd_tag, {5'd6, 5'd0, 5'd4, 5'd3});
      chk("cnd_ctrl",  out_ctrl, {6'd4, 6'd0, 6'd2, 6'd1});

      std_bundle();
      set_lane(3, 1'b1, 1'b0, 1'b0, 6'h2A, 5'd7, 5'd2);
      tick();
      chk("st_valid", out_valid, 4'b1111);
      chk("st_tag",   out_rd_tag, {5'd0, 5'd5, 5'd4, 5'd3});
      chk("st_ctrl",  out_ctrl, {6'h2A, 6'd3, 6'd2, 6'd1});

      std_bundle();
      mispred = 1'b1;
      tick();
      chk("mp_load_valid", out_valid, 4'b1111);
      chk("mp_load_tag",   out_rd_tag, {5'd6, 5'd5, 5'd4, 5'd3});
      mispred = 1'b0;
      tick();
      chk("mp_fl_valid", out_valid, 0);
      chk("mp_fl_tag",   out_rd_tag, 0);
      chk("mp_fl_ctrl",  out_ctrl, 0);
      tick();
      chk("mp_after", out_valid, 4'b1111);

      set_lane(1, 1'b0, 1'b0, 1'b1, 6'd2, 5'd4, 5'd11);
      fill_src(8'hB2);
      exp_src = in_src;
      mispred = 1'b1;
      tick();
      chk("stl_load_valid", out_valid, 4'b1101);
      chk("stl_load_tag",   out_rd_tag, {5'd6, 5'd5, 5'd0, 5'd3});
      mispred = 1'b0;
      stall = 1'b1;
      std_bundle();
      set_lane(0, 1'b1, 1'b0, 1'b1, 6'd9, 5'd17, 5'd3);
      fill_src(8'hC3);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("stl_hold_valid", out_valid, 4'b1101);
         chk("stl_hold_tag",   out_rd_tag, {5'd6, 5'd5, 5'd0, 5'd3});
         chk("stl_hold_ctrl",  out_ctrl, {6'd4, 6'd3, 6'd0, 6'd1});
         chk("stl_hold_src",   out_src, exp_src);
      end
      stall = 1'b0;
      tick();
      chk("stl_fl_valid", out_valid, 0);
      chk("stl_fl_tag",   out_rd_tag, 0);
      chk("stl_fl_ctrl",  out_ctrl, 0);
      tick();
      chk("stl_after_valid", out_valid, 4'b1111);
      chk("stl_after_tag",   out_rd_tag, {5'd6, 5'd5, 5'd4, 5'd17});

      std_bundle();
      mispred = 1'b1;
      tick();
      mispred = 1'b0;
      stall = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      chk("rst_stl_valid", out_valid, 0);
      chk("rst_stl_tag",   out_rd_tag, 0);
      rst = 1'b0;
      stall = 1'b0;
      tick();
      chk("rst_drop_flush", out_valid, 4'b1111);
      chk("rst_drop_tag",   out_rd_tag, {5'd6, 5'd5, 5'd4, 5'd3});

`ifdef VLIW_STAGE_REG_PERF_EN
      rst = 1'b1;
      tick();
      chk("perf_rst", squash_cnt, 0);
      rst = 1'b0;
      std_bundle();
      in_cnd = 4'b0011;
      tick();
      chk("perf_two", squash_cnt, 2);
      stall = 1'b1;
      tick();
      chk("perf_stall", squash_cnt, 2);
      stall = 1'b0;
      mispred = 1'b1;
      tick();
      mispred = 1'b0;
      tick();
      chk("perf_flush", squash_cnt, 8);
      repeat (40000) tick();
      chk("perf_sat", squash_cnt, 16'hFFFF);
      rst = 1'b1;
      tick();
      chk("perf_clr", squash_cnt, 0);
      rst = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vliw_stage_reg.md
VLIW_STAGE_REG -- requirements
Module: vliw_stage_reg

Interface
REQ-001 Parameter NUM_LANES, default 4, number of issue lanes (slots).
REQ-002 Parameter NUM_SRC, default 3, source operands per lane.
REQ-003 Parameter DATA_W, default 16, operand width.
REQ-004 Parameter TAG_W, default 5, register tag width; tag 0 means no writeback.
REQ-005 Parameter CTRL_W, default 6, per-lane control field width.
REQ-006 Port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-007 Port rst, input, 1, synchronous active-high reset.
REQ-008 Port stall, input, 1, hold all stage contents.
REQ-009 Port mispred, input, 1, branch mispredict; registered before use as the flush request.
REQ-010 Port in_valid, input, NUM_LANES, lane carries an instruction.
REQ-011 Port in_cnd, input, NUM_LANES, predicate false; squash the lane.
REQ-012 Port in_wr_en, input, NUM_LANES, lane writes Rd; 0 for store, NOP and JMPI.
REQ-013 Port in_ctrl, input, NUM_LANES*CTRL_W, per-lane control.
REQ-014 Port in_src, input, NUM_LANES*NUM_SRC*DATA_W, operands; lane-major, then source-major.
REQ-015 Port in_rd_tag, input, NUM_LANES*TAG_W, destination tags.
REQ-016 Port in_imm, input, NUM_LANES*TAG_W, immediates.
REQ-017 Ports out_valid, out_ctrl, out_src, out_rd_tag and out_imm, outputs, same widths as the inputs, registered stage contents.

Function
REQ-018 Stage latency SHALL be one cycle; all outputs are driven directly by flops.
REQ-019 flush_pend SHALL be set one cycle after mispred=1 is sampled.
REQ-020 Priority each cycle SHALL be rst, then stall, then flush_pend, then normal load.
REQ-021 When stall=1, all outputs SHALL hold.
REQ-022 When stall=1, flush_pend SHALL stay set until the first non-stalled cycle consumes it; unlike the prior stage register, a flush is never lost under stall.
REQ-023 A flush SHALL clear out_valid, out_ctrl and out_rd_tag in every lane, clear flush_pend, and leave out_src and out_imm don't-care.
REQ-024 A normal load SHALL capture in_src and in_imm for every lane unconditionally.
REQ-025 In a normal load, lane i is squashed when in_valid[i]=0 or in_cnd[i]=1; a squashed lane SHALL get out_valid[i]=0, ctrl=0 and rd_tag=0.
REQ-026 In a normal load, an unsquashed lane SHALL get out_valid=1 and ctrl=in_ctrl.
REQ-027 In a normal load, an unsquashed lane's rd_tag SHALL be in_rd_tag when in_wr_en=1 and 0 otherwise.
REQ-028 If mispred=1 and stall=0 in the same cycle, the normal load SHALL occur and the flush applies on the following non-stalled cycle.
REQ-029 Lanes SHALL be fully independent; squashing one lane never affects another.

Reset
REQ-030 While rst=1, every output SHALL be zero, and flush_pend and the perf counter SHALL be cleared.
REQ-031 Reset asserted mid-stall or with a flush pending SHALL discard the pending flush.

Configuration
REQ-032 When VLIW_STAGE_REG_PERF_EN is defined, output squash_cnt (16 bits) SHALL add, on each non-stalled, non-reset cycle, the number of lanes that load as squashed or flushed.
REQ-033 squash_cnt SHALL saturate at 0xFFFF.
REQ-034 When VLIW_STAGE_REG_PERF_EN is undefined, the squash_cnt port and its logic SHALL be absent.

Structure
REQ-035 Package cpu_pkg SHALL hold the default widths (DATA_W, TAG_W, CTRL_W).
REQ-036 cpu_pkg SHALL hold the constant NO_WB_TAG = 0.
REQ-037 cpu_pkg SHALL hold the lane-index helper functions.
REQ-038 One sub-module, vliw_lane_reg, SHALL implement a single lane and be instantiated NUM_LANES times via generate.
REQ-039 vliw_stage_reg SHALL own flush_pend and the perf counter.

Verification
REQ-040 All lanes valid, wr_en=1, rd_tags 3/4/5/6, stall=0: next cycle out_rd_tag=3/4/5/6 and out_valid=4'b1111.
REQ-041 in_cnd=4'b0100 with rd_tag 9 on lane 2: lane 2 outputs rd_tag=0, valid=0 and ctrl=0; other lanes load normally.
REQ-042 mispred pulsed for 1 cycle, then stall=1 for 3 cycles: outputs hold for 3 cycles, then all lanes flush on the first unstalled edge.
REQ-043 mispred=1 with stall=0: the loaded bundle appears for one cycle, then the next edge flushes.
REQ-044 Store on lane 3 (wr_en=0, rd_tag=7): out_valid[3]=1, out_rd_tag[3]=0 and out_ctrl[3]=in_ctrl.
REQ-045 With PERF_EN defined and 2 lanes squashed each cycle for 40000 cycles: squash_cnt saturates at 0xFFFF; rst=1 returns it to 0.
